// File: rtl/cdb_broadcast.sv
// Common Data Bus producer: one-entry holding buffer per FU, round-robin
// grant, registered single broadcast per cycle toward the ROB.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   squash                : ROB head squash, flushes buffers and broadcast
//   fu_valid/rob_idx/value: per-FU result inputs (flattened, FU0 in LSBs)
//   fu_ready              : per-FU accept, combinational from state + squash
//   complete_enable       : registered broadcast valid
//   complete_rob_entry    : registered ROB tag being completed
//   value                 : registered broadcast value
//   cdb_full              : every holding buffer occupied
module cdb_broadcast #(
   parameter int NUM_FU      = 4,
   parameter int XLEN        = 32,
   parameter int ROB_IDX_LEN = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          squash,
   input  logic [NUM_FU-1:0]             fu_valid,
   input  logic [NUM_FU*ROB_IDX_LEN-1:0] fu_rob_idx,
   input  logic [NUM_FU*XLEN-1:0]        fu_value,
   output logic [NUM_FU-1:0]             fu_ready,
   output logic                          complete_enable,
   output logic [ROB_IDX_LEN-1:0]        complete_rob_entry,
   output logic [XLEN-1:0]               value,
   output logic                          cdb_full
);

   localparam int PW = $clog2(NUM_FU);

   logic [NUM_FU-1:0]      r_buf_valid;
   logic [ROB_IDX_LEN-1:0] r_buf_idx [NUM_FU];
   logic [XLEN-1:0]        r_buf_val [NUM_FU];
   logic [PW-1:0]          r_rr_ptr;

   logic [NUM_FU-1:0]      w_grant;
   logic                   w_gnt_any;
   logic [PW-1:0]          w_gnt_idx;
   logic [PW-1:0]          w_nxt_ptr;

   // Scan from r_rr_ptr upward, wrapping; the first occupied buffer wins.
   always_comb begin
      logic [PW:0]   s;
      logic [PW-1:0] j;
      w_grant   = '0;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      s         = '0;
      j         = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         s = {1'b0, r_rr_ptr} + (PW+1)'(k);
         if (s >= (PW+1)'(NUM_FU))
            s = s - (PW+1)'(NUM_FU);
         j = s[PW-1:0];
         if (!w_gnt_any && r_buf_valid[j]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = j;
         end
      end
      if (w_gnt_any)
         w_grant[w_gnt_idx] = 1'b1;
   end

   assign w_nxt_ptr = (w_gnt_idx == PW'(NUM_FU-1)) ?
                      '0 : w_gnt_idx + PW'(1);

   // A buffer being drained this cycle can take a new result at once.
   assign fu_ready = {NUM_FU{!squash}} & (~r_buf_valid | w_grant);
   assign cdb_full = &r_buf_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_buf_valid        <= '0;
         r_rr_ptr           <= '0;
         complete_enable    <= 1'b0;
         complete_rob_entry <= '0;
         value              <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            r_buf_idx[i] <= '0;
            r_buf_val[i] <= '0;
         end
      end else if (squash) begin
         r_buf_valid     <= '0;
         complete_enable <= 1'b0;
      end else begin
         if (w_gnt_any) begin
            complete_enable    <= 1'b1;
            complete_rob_entry <= r_buf_idx[w_gnt_idx];
            value              <= r_buf_val[w_gnt_idx];
            r_rr_ptr           <= w_nxt_ptr;
            r_buf_valid[w_gnt_idx] <= 1'b0;
         end else begin
            complete_enable <= 1'b0;
         end
         // Later assignment wins: a refill overrides the grant clear.
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf_idx[i]   <=
                  fu_rob_idx[i*ROB_IDX_LEN +: ROB_IDX_LEN];
               r_buf_val[i]   <= fu_value[i*XLEN +: XLEN];
            end
         end
      end
   end

endmodule
